// File: rtl/mar_pkg.sv
// Shared definitions for the memory address register generator.
//   op_e      : 3-bit operation encodings driven on the op port
//   sel_width : default select width for a given number of load sources
package mar_pkg;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_LOAD    = 3'd1,
    OP_INC     = 3'd2,
    OP_DEC     = 3'd3,
    OP_SAVE    = 3'd4,
    OP_RESTORE = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  // A single source still needs a 1-bit select port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mar_next_addr.sv
// Combinational step logic for INC/DEC with a programmable inclusive upper bound.
//   cur       in  ADDR_W  current address
//   limit     in  ADDR_W  inclusive upper bound
//   op        in  op_e    requested operation (only INC/DEC change the address)
//   nxt       out ADDR_W  stepped address
//   hit_bound out 1       the step ran into a bound
module mar_next_addr
  import mar_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic [ADDR_W-1:0] cur,
  input  logic [ADDR_W-1:0] limit,
  input  op_e               op,
  output logic [ADDR_W-1:0] nxt,
  output logic              hit_bound
);

  always_comb begin
    nxt       = cur;
    hit_bound = 1'b0;
    case (op)
      OP_INC: begin
        // Bound check comes first so cur + 1 can never overflow past limit.
        if (cur >= limit) begin
          nxt       = (WRAP_MODE != 0) ? '0 : limit;
          hit_bound = 1'b1;
        end else begin
          nxt = cur + ADDR_W'(1);
        end
      end
      OP_DEC: begin
        if (cur == '0) begin
          nxt       = (WRAP_MODE != 0) ? limit : '0;
          hit_bound = 1'b1;
        end else if (cur > limit) begin
          // An out-of-range loaded value snaps back into range.
          nxt = limit;
        end else begin
          nxt = cur - ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mar_gen.sv
// Memory address register with selectable load sources, bounded up/down
// stepping, a one-deep save/restore shadow and one-cycle status pulses.
//   clk         in  1            clock
//   clr         in  1            synchronous active-high reset
//   d_in        in  NSRC*ADDR_W  packed load sources, source i at [i*ADDR_W +: ADDR_W]
//   select      in  SEL_W        load source index
//   g1, g2      in  1            enables, both must be high
//   op          in  3            operation code (mar_pkg::op_e)
//   limit       in  ADDR_W       inclusive upper bound
//   mar_out     out ADDR_W       registered address
//   saved_valid out 1            shadow holds a saved address
//   bound       out 1            pulse: INC/DEC hit a bound
//   err         out 1            pulse: illegal request ignored
module mar_gen
  import mar_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NSRC      = 4,
  parameter int unsigned SEL_W     = sel_width(NSRC),
  parameter int unsigned WRAP_MODE = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NSRC*ADDR_W-1:0] d_in,
  input  logic [SEL_W-1:0]       select,
  input  logic                   g1,
  input  logic                   g2,
  input  logic [2:0]             op,
  input  logic [ADDR_W-1:0]      limit,
  output logic [ADDR_W-1:0]      mar_out,
  output logic                   saved_valid,
  output logic                   bound,
  output logic                   err
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] shadow_q, shadow_d;
  logic              valid_q, valid_d;
  logic              bound_q, bound_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] src_addr, step_addr;
  logic              src_ok, step_bound, en;
  op_e               op_c;

  assign en   = g1 & g2;
  assign op_c = op_e'(op);

  // Source mux; src_ok stays low when select points past the last source.
  always_comb begin
    src_addr = '0;
    src_ok   = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(select) == i) begin
        src_addr = d_in[i*ADDR_W +: ADDR_W];
        src_ok   = 1'b1;
      end
    end
  end

  mar_next_addr #(
    .ADDR_W   (ADDR_W),
    .WRAP_MODE(WRAP_MODE)
  ) u_next_addr (
    .cur      (mar_q),
    .limit    (limit),
    .op       (op_c),
    .nxt      (step_addr),
    .hit_bound(step_bound)
  );

  always_comb begin
    mar_d    = mar_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    bound_d  = 1'b0;
    err_d    = 1'b0;
    if (en) begin
      unique case (op_c)
        OP_HOLD: ;
        OP_LOAD: begin
          if (src_ok) mar_d = src_addr;
          else        err_d = 1'b1;
        end
        OP_INC, OP_DEC: begin
          mar_d   = step_addr;
          bound_d = step_bound;
        end
        OP_SAVE: begin
          shadow_d = mar_q;
          valid_d  = 1'b1;
        end
        OP_RESTORE: begin
          if (valid_q) begin
            mar_d   = shadow_q;
            valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLEAR: mar_d = '0;
        OP_RSVD:  err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mar_q    <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      bound_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mar_q    <= mar_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      bound_q  <= bound_d;
      err_q    <= err_d;
    end
  end

  assign mar_out     = mar_q;
  assign saved_valid = valid_q;
  assign bound       = bound_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mar_gen.sv
// Bench for mar_gen: a wrapping 4-source instance and a saturating 3-source
// instance share one stimulus stream; a behavioural model is compared every cycle.
module tb_mar_gen;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] d_in;
  logic [1:0]  select;
  logic        g1, g2;
  logic [2:0]  op;
  logic [3:0]  limit;

  logic [3:0] w_mar, s_mar;
  logic        w_sv, w_bd, w_er, s_sv, s_bd, s_er;

  int n_cmp = 0;
  int n_bad = 0;

  // index 0 = wrapping/4 sources, index 1 = saturating/3 sources
  int m_mar[2], m_sh[2], m_sv[2], m_bd[2], m_er[2];

  always #5 clk = ~clk;

  mar_gen #(.ADDR_W(4), .NSRC(4), .SEL_W(2), .WRAP_MODE(1)) dut_w (
    .clk(clk), .clr(clr), .d_in(d_in), .select(select), .g1(g1), .g2(g2), .op(op),
    .limit(limit), .mar_out(w_mar), .saved_valid(w_sv), .bound(w_bd), .err(w_er)
  );

  mar_gen #(.ADDR_W(4), .NSRC(3), .SEL_W(2), .WRAP_MODE(0)) dut_s (
    .clk(clk), .clr(clr), .d_in(d_in[11:0]), .select(select), .g1(g1), .g2(g2), .op(op),
    .limit(limit), .mar_out(s_mar), .saved_valid(s_sv), .bound(s_bd), .err(s_er)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one register transfer per clock, straight from the op rules.
  task automatic model_step(input int k, input bit wrap, input int nsrc);
    int lim, sel;
    lim = int'(limit);
    sel = int'(select);
    if (clr) begin
      m_mar[k] = 0; m_sh[k] = 0; m_sv[k] = 0; m_bd[k] = 0; m_er[k] = 0;
      return;
    end
    m_bd[k] = 0;
    m_er[k] = 0;
    if (!(g1 && g2)) return;
    case (int'(op))
      1: if (sel < nsrc) m_mar[k] = int'(d_in >> (4 * sel)) & 15;
         else m_er[k] = 1;
      2: if (m_mar[k] >= lim) begin m_mar[k] = wrap ? 0 : lim; m_bd[k] = 1; end
         else m_mar[k] = m_mar[k] + 1;
      3: if (m_mar[k] == 0) begin m_mar[k] = wrap ? lim : 0; m_bd[k] = 1; end
         else if (m_mar[k] > lim) m_mar[k] = lim;
         else m_mar[k] = m_mar[k] - 1;
      4: begin m_sh[k] = m_mar[k]; m_sv[k] = 1; end
      5: if (m_sv[k] != 0) begin m_mar[k] = m_sh[k]; m_sv[k] = 0; end
         else m_er[k] = 1;
      6: m_mar[k] = 0;
      7: m_er[k] = 1;
      default: ;
    endcase
  endtask

  // Inputs change only on negedges, so the model sees the same values the DUT samples.
  always @(posedge clk) begin
    model_step(0, 1'b1, 4);
    model_step(1, 1'b0, 3);
    #1;
    cmp("w.mar_out", w_mar, m_mar[0]);
    cmp("w.saved_valid", w_sv, m_sv[0]);
    cmp("w.bound", w_bd, m_bd[0]);
    cmp("w.err", w_er, m_er[0]);
    cmp("s.mar_out", s_mar, m_mar[1]);
    cmp("s.saved_valid", s_sv, m_sv[1]);
    cmp("s.bound", s_bd, m_bd[1]);
    cmp("s.err", s_er, m_er[1]);
  end

  task automatic apply(input logic c, input logic [2:0] o, input logic [1:0] s,
                       input logic a, input logic b);
    clr = c; op = o; select = s; g1 = a; g2 = b;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; d_in = '0; select = '0; g1 = 1'b0; g2 = 1'b0; op = 3'd0; limit = 4'hF;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of an INC run with a saved address and a pending bound.
    limit = 4'h5; d_in = 16'h0003;
    apply(0, 3'd1, 2'd0, 1, 1);
    apply(0, 3'd4, 2'd0, 1, 1);
    cmp("rst pre saved_valid", w_sv, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("rst pre mar", w_mar, 4'h5);
    apply(1, 3'd2, 2'd0, 1, 1);
    cmp("rst mar", w_mar, 0);
    cmp("rst saved_valid", w_sv, 0);
    cmp("rst bound", w_bd, 0);
    cmp("rst err", w_er, 0);

    // Gating: g2 low blocks the load.
    limit = 4'hF; d_in = 16'h5A73;
    apply(0, 3'd1, 2'd2, 1, 0);
    cmp("gate off mar", w_mar, 0);
    apply(0, 3'd1, 2'd2, 1, 1);
    cmp("gate on mar", w_mar, 4'hA);
    cmp("gate on model", m_mar[0], 4'hA);

    // Wrap at limit 0xC.
    limit = 4'hC; d_in = 16'h000B;
    apply(0, 3'd1, 2'd0, 1, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("wrap inc1 mar", w_mar, 4'hC);
    cmp("wrap inc1 bound", w_bd, 0);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("wrap inc2 mar", w_mar, 0);
    cmp("wrap inc2 bound", w_bd, 1);
    cmp("wrap inc2 model", m_mar[0], 0);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("wrap inc3 mar", w_mar, 1);
    cmp("wrap inc3 bound", w_bd, 0);
    apply(0, 3'd6, 2'd0, 1, 1);
    apply(0, 3'd3, 2'd0, 1, 1);
    cmp("wrap dec0 mar", w_mar, 4'hC);
    cmp("wrap dec0 bound", w_bd, 1);

    // Saturate at limit 9.
    limit = 4'h9; d_in = 16'h00F9;
    apply(0, 3'd1, 2'd0, 1, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("sat inc mar", s_mar, 4'h9);
    cmp("sat inc bound", s_bd, 1);
    cmp("sat inc model", m_mar[1], 9);
    apply(0, 3'd1, 2'd1, 1, 1);
    cmp("sat load F", s_mar, 4'hF);
    apply(0, 3'd3, 2'd0, 1, 1);
    cmp("sat dec snap", s_mar, 4'h9);
    apply(0, 3'd3, 2'd0, 1, 1);
    cmp("sat dec mar", s_mar, 4'h8);

    // Save / restore.
    limit = 4'hF; d_in = 16'h0006;
    apply(0, 3'd1, 2'd0, 1, 1);
    apply(0, 3'd4, 2'd0, 1, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    apply(0, 3'd2, 2'd0, 1, 1);
    cmp("sr inc2 mar", w_mar, 4'h8);
    apply(0, 3'd5, 2'd0, 1, 1);
    cmp("sr restore mar", w_mar, 4'h6);
    cmp("sr restore valid", w_sv, 0);
    apply(0, 3'd5, 2'd0, 1, 1);
    cmp("sr 2nd restore err", w_er, 1);
    cmp("sr 2nd restore mar", w_mar, 4'h6);

    // Illegal select on the 3-source instance, then the reserved op.
    d_in = 16'h1234;
    apply(0, 3'd1, 2'd3, 1, 1);
    cmp("sel3 s err", s_er, 1);
    cmp("sel3 s mar", s_mar, 4'h6);
    cmp("sel3 w err", w_er, 0);
    cmp("sel3 w mar", w_mar, 4'h1);
    apply(0, 3'd7, 2'd0, 1, 1);
    cmp("rsvd err", w_er, 1);
    apply(0, 3'd0, 2'd0, 1, 1);
    cmp("hold err clear", w_er, 0);

    // Randomised run; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) limit = 4'($urandom);
      d_in = 16'($urandom);
      apply(($urandom_range(0, 63) == 0), 3'($urandom), 2'($urandom),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
    end

    apply(0, 3'd0, 2'd0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mar_gen.md
Name: mar_gen

Overview:
- Parametrised next-generation memory address register for the Tiny Tapeout top.
- Replaces the fixed 4-bit MAR; loads from NSRC selectable sources, with up/down auto-increment bounded by a programmable limit.
- Adds a one-deep save/restore shadow register and boundary/error status pulses.
- Output drives the address field of uo_out; all state is registered on clk.

Parameters:
- ADDR_W, 4: address width in bits (≥2).
- NSRC, 4: number of load sources (≥1).
- SEL_W, 2: select width; must satisfy 2**SEL_W ≥ NSRC.
- WRAP_MODE, 1: 1 = wrap at bounds; 0 = saturate at bounds.

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- d_in  in  NSRC*ADDR_W  packed load sources; source i = d_in[i*ADDR_W +: ADDR_W]
- select  in  SEL_W  load source index
- g1  in  1  enable 1
- g2  in  1  enable 2
- op  in  3  operation code
- limit  in  ADDR_W  upper address bound (inclusive)
- mar_out  out  ADDR_W  registered address
- saved_valid  out  1  shadow register holds a saved address
- bound  out  1  one-cycle pulse: INC/DEC hit a bound
- err  out  1  one-cycle pulse: illegal request ignored

Behaviour:
- Decided: one clock (clk); reset (clr) is synchronous and active-high.
- Reset: when clr=1 at a clk edge, mar_out=0, shadow=0, saved_valid=0, bound=0, err=0. clr has priority over everything, including a mid-sequence operation. No state survives.
- Enable: en = g1 & g2. When en=0: state holds; bound=0, err=0.
- Latency: every op takes effect at the clk edge it is sampled on; the result is visible on mar_out the same cycle after the edge (1-cycle latency).
- bound and err are registered pulses that clear the following cycle unless retriggered.
- Ops, when en=1:
  - 0 HOLD: no change.
  - 1 LOAD: mar_out <= source[select]. If select ≥ NSRC: no change, err=1.
  - 2 INC: if mar_out ≥ limit: WRAP_MODE=1 gives 0; WRAP_MODE=0 gives limit. bound=1 in both cases. Otherwise mar_out+1.
  - 3 DEC: if mar_out==0: WRAP_MODE=1 gives limit; WRAP_MODE=0 gives 0. bound=1 in both cases. Otherwise, if mar_out > limit, gives limit; else mar_out-1.
  - 4 SAVE: shadow <= mar_out; saved_valid <= 1; mar_out unchanged. A repeated SAVE overwrites.
  - 5 RESTORE: if saved_valid: mar_out <= shadow, saved_valid <= 0. Else no change, err=1.
  - 6 CLEAR: mar_out <= 0; shadow and saved_valid untouched.
  - 7: reserved; behaves as HOLD with err=1.
- Width rules:
  - Arithmetic is modulo 2**ADDR_W internally; the bound check precedes the increment, so no overflow escapes.
  - limit=0: INC always returns 0 (wrap) or stays 0 (saturate), with bound=1.
  - LOAD values above limit are accepted as-is; the next INC treats them as at the bound.
- Simultaneous events:
  - Only one op per cycle, so there are no internal conflicts.
  - limit changing on the same edge as INC/DEC: the value sampled at that edge is used.

Decomposition:
- Package mar_pkg holds:
  - 3-bit op encodings: OP_HOLD, OP_LOAD, OP_INC, OP_DEC, OP_SAVE, OP_RESTORE, OP_CLEAR, OP_RSVD.
  - A clog2-based helper for SEL_W.
- One sub-module, mar_next_addr: combinational next-address/bound computation from (mar_out, limit, op, WRAP_MODE).
- The top holds the registers, source mux, shadow and flags.

Test Plan:
- Reset: clr=1 mid-INC sequence with saved_valid=1 -> next edge mar_out=0, saved_valid=0, bound=0, err=0.
- Load/gating: sources {3,7,A,5}, select=2, op=LOAD, g1=1, g2=0 -> mar_out unchanged. Then g2=1 -> mar_out=0xA next cycle.
- Wrap: WRAP_MODE=1, limit=0xC, mar_out=0xB, three INCs -> C, 0, 1, with bound=1 only on the C->0 cycle. DEC from 0 -> 0xC, bound=1.
- Saturate: WRAP_MODE=0, limit=0x9, mar_out=0x9, INC -> stays 9, bound=1. LOAD 0xF, then DEC -> 0x9, then DEC -> 0x8.
- Save/restore: mar_out=0x6, SAVE, INC×2 (0x8), RESTORE -> 0x6, saved_valid=0. A second RESTORE -> err=1, mar_out stays 0x6.
- Errors: NSRC=3 with select=3 LOAD -> err=1, no change. op=7 -> err=1 for one cycle, then err=0 on a following HOLD.
